imem_loader: RTL

Byte-stream program loader for the single-cycle CPU's instruction/data memory. It writes a program image into memory word by word: the hardware counterpart of the bench-side `$readmemh` preload. It holds the CPU in reset until the image arrives intact, then releases it. It sits between an external byte source (UART/debug bridge) and the CPU memory write port.

---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Purpose: byte-stream program loader; frames LEN_HI LEN_LO data[4N] CSUM into word writes, holds CPU until image is good.
// Latency: mem_we one cycle after the 4th byte of a word is accepted; done/error one cycle after the CSUM accept.
// Backpressure: in_ready high only in LEN_HI/LEN_LO/DATA/CSUM; memory never stalls the stream (max 1 byte/cycle).
//
// Ports:
//   clk, reset (async, active-low)   - clock and reset
//   start                            - one-cycle pulse; begins a session from IDLE/DONE/ERR
//   in_data/in_valid/in_ready        - byte stream, transfer on in_valid & in_ready at a rising edge
//   mem_we/mem_addr/mem_wdata        - registered memory write port, one strobe per word
//   cpu_hold                         - high while the CPU must stay in reset
//   done/error                       - sticky session result until the next start
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  // Largest word count that fits between BASE_ADDR and the top of memory.
  // Held at 17 bits so a 16-bit length of up to 65535 compares without wrap.
  localparam logic [16:0]           MAX_WORDS = 17'((64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR));
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nxt;

  logic [7:0]  len_hi;     // first length byte, held until LEN_LO completes the count
  logic [15:0] len;        // word count N
  logic [1:0]  bcnt;       // byte position inside the current word
  logic [15:0] wcnt;       // index of the word being assembled
  logic [23:0] asm_q;      // first three bytes of the current word, oldest in [23:16]
  logic [7:0]  csum;       // running XOR of every frame byte before CSUM

  logic        acc;
  logic        restart;
  logic        last_byte;
  logic        last_word;
  logic [15:0] n_rx;

  assign acc       = in_valid & in_ready;
  assign restart   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign last_byte = (bcnt == 2'd3);
  assign last_word = (wcnt == len - 16'd1);
  assign n_rx      = {len_hi, in_data};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ({1'b0, n_rx} > MAX_WORDS) state_nxt = S_ERR;
          else if (n_rx == 16'd0)       state_nxt = S_CSUM;
          else                          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && last_byte && last_word) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nxt = S_LEN_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, checksum and the write port.
  // restart only fires in states where in_ready is low, so it never races a byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi    <= '0;
      len       <= '0;
      bcnt      <= '0;
      wcnt      <= '0;
      asm_q     <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        bcnt  <= '0;
        wcnt  <= '0;
        asm_q <= '0;
        csum  <= '0;
      end else if (acc) begin
        case (state)
          S_LEN_HI: begin
            len_hi <= in_data;
            csum   <= csum ^ in_data;
          end
          S_LEN_LO: begin
            len  <= n_rx;
            csum <= csum ^ in_data;
          end
          S_DATA: begin
            csum <= csum ^ in_data;
            if (last_byte) begin
              mem_we    <= 1'b1;
              mem_wdata <= {asm_q, in_data};
              mem_addr  <= BASE + ADDR_WIDTH'(wcnt);
              wcnt      <= wcnt + 16'd1;
              bcnt      <= 2'd0;
            end else begin
              asm_q <= {asm_q[15:0], in_data};
              bcnt  <= bcnt + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
